// File: rtl/je_fifo_drain.sv
// Drains a byte-wide FIFO (byte address + data per entry) into 32-bit word writes,
// merging bytes that land in the same word and issuing partial words after an idle hold.
module je_fifo_drain #(
    parameter int ASZ  = 17,
    parameter int HOLD = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [ASZ+7:0] fifo_data,
    input  logic           fifo_empty,
    output logic           fifo_read,
    input  logic           flush,
    output logic           mem_req,
    output logic [ASZ-3:0] mem_addr,
    output logic [31:0]    mem_wdata,
    output logic [3:0]     mem_be,
    input  logic           mem_ack,
    output logic           idle,
    output logic [1:0]     dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] ISSUE  = 2'd3;

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic           empty_q;
    logic [ASZ-3:0] buf_addr;
    logic [31:0]    buf_data;
    logic [3:0]     buf_be;
    logic [HW-1:0]  hold_cnt;

    logic           head_valid;
    logic [ASZ-3:0] head_word;
    logic [1:0]     head_lane;
    logic [7:0]     head_byte;
    logic           buf_empty;
    logic           mergeable;
    logic           merge;
    logic           hold_done;
    logic [3:0]     lane_mask;
    logic [31:0]    lane_data;

    // The FIFO head is only trusted once fifo_empty has been low for two samples.
    assign head_valid = !fifo_empty && !empty_q;
    assign head_word  = fifo_data[ASZ+7:10];
    assign head_lane  = fifo_data[9:8];
    assign head_byte  = fifo_data[7:0];
    assign buf_empty  = (buf_be == 4'b0000);
    assign lane_mask  = 4'b0001 << head_lane;
    assign lane_data  = {24'b0, head_byte} << {head_lane, 3'b000};
    assign mergeable  = buf_empty || ((buf_addr == head_word) && !buf_be[head_lane]);
    assign merge      = (state == CHECK) && head_valid && mergeable;
    assign hold_done  = (hold_cnt == HW'(HOLD - 1));

    assign fifo_read = merge;
    assign mem_req   = (state == ISSUE);
    assign mem_addr  = buf_addr;
    assign mem_wdata = buf_data;
    assign mem_be    = buf_be;
    assign idle      = (state == IDLE) && buf_empty;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (head_valid) state_nxt = CHECK;
            end
            CHECK: begin
                if (head_valid) begin
                    if (!mergeable)                           state_nxt = ISSUE;
                    else if ((buf_be | lane_mask) == 4'b1111) state_nxt = ISSUE;
                    else                                      state_nxt = SETTLE;
                end else if (buf_empty) begin
                    state_nxt = IDLE;
                end else if (flush || hold_done) begin
                    state_nxt = ISSUE;
                end
            end
            SETTLE: state_nxt = CHECK;
            ISSUE: begin
                if (mem_ack) state_nxt = CHECK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            empty_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            empty_q <= fifo_empty;
        end
    end

    // Word buffer: lanes not yet written stay zero because the buffer is cleared on every ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_addr <= '0;
            buf_data <= '0;
            buf_be   <= '0;
            hold_cnt <= '0;
        end else if (merge) begin
            buf_addr <= head_word;
            buf_data <= buf_data | lane_data;
            buf_be   <= buf_be | lane_mask;
            hold_cnt <= '0;
        end else if ((state == ISSUE) && mem_ack) begin
            buf_addr <= '0;
            buf_data <= '0;
            buf_be   <= '0;
            hold_cnt <= '0;
        end else if ((state == CHECK) && !head_valid && !buf_empty && !flush && !hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_je_fifo_drain.sv
// Bench for je_fifo_drain: a queue-backed FIFO, a byte-merge reference model feeding
// an expected-write queue, and scenario tasks for the directed and random cases.
module tb_je_fifo_drain;

    localparam int ASZ  = 17;
    localparam int HOLD = 8;
    localparam int WW   = (ASZ - 2) + 32 + 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [ASZ+7:0] fifo_data = '0;
    logic           fifo_empty = 1'b1;
    logic           fifo_read;
    logic           flush = 1'b0;
    logic           mem_req;
    logic [ASZ-3:0] mem_addr;
    logic [31:0]    mem_wdata;
    logic [3:0]     mem_be;
    logic           mem_ack = 1'b0;
    logic           idle;
    logic [1:0]     dbg_state;

    logic [WW-1:0]  exp_q[$];
    logic [ASZ+7:0] fq[$];
    logic [ASZ+7:0] batch[$];

    int      checks = 0;
    int      failures = 0;
    int      rd_count = 0;
    int      wr_count = 0;
    bit      rd_seen = 1'b0;
    bit      ack_rand = 1'b0;
    logic    ack_fixed = 1'b1;
    bit      pend = 1'b0;
    logic [WW-1:0] pend_val = '0;
    logic [WW-1:0] last_wr = '0;

    je_fifo_drain #(.ASZ(ASZ), .HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .idle(idle),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // FIFO with registered head and the memory ack driver, both updated just after the edge.
    always @(posedge clk) begin
        #1;
        if (rd_seen) begin
            if (fq.size() > 0) void'(fq.pop_front());
            rd_count++;
        end
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() > 0) ? fq[0] : '0;
        mem_ack    = ack_rand ? 1'($urandom_range(0, 1)) : ack_fixed;
    end

    // Write monitor and scoreboard.
    always @(negedge clk) begin
        logic [WW-1:0] got;
        logic [WW-1:0] exp;
        rd_seen = fifo_read;
        got = {mem_addr, mem_wdata, mem_be};
        if (fifo_read === 1'b1) begin
            checks++;
            if (fifo_empty !== 1'b0) begin
                failures++;
                $display("FAIL read_while_empty fifo_empty=%b required 0", fifo_empty);
            end
        end
        if (mem_req === 1'b1) begin
            if (pend) begin
                checks++;
                if (got !== pend_val) begin
                    failures++;
                    $display("FAIL req_stable got=%h required %h", got, pend_val);
                end
            end
            if (mem_ack === 1'b1) begin
                wr_count++;
                last_wr = got;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got=%h required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL write_data got=%h required %h", got, exp);
                    end
                end
                pend = 1'b0;
            end else begin
                pend = 1'b1;
                pend_val = got;
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic push(input logic [ASZ-1:0] a, input logic [7:0] d);
        fq.push_back({a, d});
        batch.push_back({a, d});
    endtask

    // Greedy merge over the FIFO order: a new word or a repeated lane closes the current word.
    task automatic model_batch();
        logic [ASZ-3:0] wa, cw;
        logic [1:0]     ln;
        logic [31:0]    cd;
        logic [3:0]     cb;
        bit             cv;
        cv = 1'b0; cw = '0; cd = '0; cb = '0;
        foreach (batch[i]) begin
            wa = batch[i][ASZ+7:10];
            ln = batch[i][9:8];
            if (cv && ((wa != cw) || cb[ln])) begin
                exp_q.push_back({cw, cd, cb});
                cv = 1'b0;
            end
            if (!cv) begin
                cv = 1'b1; cw = wa; cd = '0; cb = '0;
            end
            cd[8*ln +: 8] = batch[i][7:0];
            cb[ln] = 1'b1;
            if (cb == 4'hf) begin
                exp_q.push_back({cw, cd, cb});
                cv = 1'b0;
            end
        end
        if (cv) exp_q.push_back({cw, cd, cb});
        batch.delete();
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fq.size() == 0 && fifo_empty && idle && exp_q.size() == 0) && n < 600);
        checks++;
        if (n >= 600) begin
            failures++;
            $display("FAIL %s drain_timeout writes_left=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Cycles with the FIFO empty and no request, counted after the nth pop.
    task automatic gap_after_read(input int nth, output int gap);
        int seen, n;
        seen = 0; gap = 0; n = 0;
        while (seen < nth && n < 300) begin
            @(negedge clk);
            n++;
            if (fifo_read) seen++;
        end
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (mem_req) break;
            if (fifo_empty) gap++;
        end
        if (n >= 300) gap = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (fifo_read !== 1'b0) begin failures++; $display("FAIL rst_fifo_read got=%b required 0", fifo_read); end
        if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b required 0", mem_req); end
        if (mem_addr !== '0) begin failures++; $display("FAIL rst_mem_addr got=%h required 0", mem_addr); end
        if (mem_wdata !== '0) begin failures++; $display("FAIL rst_mem_wdata got=%h required 0", mem_wdata); end
        if (mem_be !== '0) begin failures++; $display("FAIL rst_mem_be got=%b required 0", mem_be); end
        if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b required 1", idle); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (idle !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_idle idle=%b req=%b required 1 0", idle, mem_req);
        end
    endtask

    task automatic test_full_word();
        int rd0, wr0;
        rd0 = rd_count; wr0 = wr_count;
        push(17'h00100, 8'h11); push(17'h00101, 8'h22);
        push(17'h00102, 8'h33); push(17'h00103, 8'h44);
        model_batch();
        wait_drained("full_word");
        checks += 3;
        if (wr_count - wr0 != 1) begin failures++; $display("FAIL full_word_writes got=%0d required 1", wr_count - wr0); end
        if (rd_count - rd0 != 4) begin failures++; $display("FAIL full_word_reads got=%0d required 4", rd_count - rd0); end
        if (last_wr !== {15'h0040, 32'h44332211, 4'b1111}) begin
            failures++;
            $display("FAIL full_word_value got=%h required %h", last_wr, {15'h0040, 32'h44332211, 4'b1111});
        end
    endtask

    task automatic test_hold();
        int gap, wr0;
        wr0 = wr_count;
        push(17'h00005, 8'hAA); push(17'h00009, 8'hBB);
        model_batch();
        gap_after_read(2, gap);
        checks++;
        if (gap != HOLD + 1) begin failures++; $display("FAIL hold_gap got=%0d required %0d", gap, HOLD + 1); end
        wait_drained("hold");
        checks += 2;
        if (wr_count - wr0 != 2) begin failures++; $display("FAIL hold_writes got=%0d required 2", wr_count - wr0); end
        if (last_wr !== {15'h0002, 32'h0000BB00, 4'b0010}) begin
            failures++;
            $display("FAIL hold_second got=%h required %h", last_wr, {15'h0002, 32'h0000BB00, 4'b0010});
        end
    endtask

    task automatic test_dup_lane();
        int wr0;
        wr0 = wr_count;
        push(17'h00004, 8'h01); push(17'h00004, 8'h02);
        model_batch();
        wait_drained("dup_lane");
        checks += 2;
        if (wr_count - wr0 != 2) begin failures++; $display("FAIL dup_writes got=%0d required 2", wr_count - wr0); end
        if (last_wr !== {15'h0001, 32'h00000002, 4'b0001}) begin
            failures++;
            $display("FAIL dup_second got=%h required %h", last_wr, {15'h0001, 32'h00000002, 4'b0001});
        end
    endtask

    task automatic test_stall();
        int n;
        ack_fixed = 1'b0;
        push(17'h00200, 8'hA1); push(17'h00201, 8'hB2);
        push(17'h00202, 8'hC3); push(17'h00203, 8'hD4);
        push(17'h00020, 8'h5A);
        model_batch();
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 100);
        for (int i = 0; i < 20; i++) begin
            checks += 2;
            if (mem_req !== 1'b1) begin failures++; $display("FAIL stall_req cycle=%0d got=%b required 1", i, mem_req); end
            if (fifo_read !== 1'b0) begin failures++; $display("FAIL stall_read cycle=%0d got=%b required 0", i, fifo_read); end
            @(negedge clk);
        end
        ack_fixed = 1'b1;
        wait_drained("stall");
    endtask

    task automatic test_flush();
        int gap;
        flush = 1'b1;
        push(17'h00003, 8'h7F);
        model_batch();
        gap_after_read(1, gap);
        checks++;
        if (gap != 2) begin failures++; $display("FAIL flush_gap got=%0d required 2", gap); end
        wait_drained("flush");
        checks++;
        if (last_wr !== {15'h0000, 32'h7F000000, 4'b1000}) begin
            failures++;
            $display("FAIL flush_value got=%h required %h", last_wr, {15'h0000, 32'h7F000000, 4'b1000});
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_issue();
        int n, wr0, reqs;
        ack_fixed = 1'b0;
        flush = 1'b1;
        push(17'h00044, 8'h3C);
        model_batch();
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 100);
        #2;
        reset = 1'b1;
        #1;
        checks += 2;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_issue_req got=%b required 0", mem_req); end
        if (idle !== 1'b1) begin failures++; $display("FAIL rst_issue_idle got=%b required 1", idle); end
        exp_q.delete();
        fq.delete();
        batch.delete();
        flush = 1'b0;
        ack_fixed = 1'b1;
        wr0 = wr_count;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        reqs = 0;
        repeat (30) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        checks += 3;
        if (reqs != 0) begin failures++; $display("FAIL rst_no_retry reqs=%0d required 0", reqs); end
        if (wr_count != wr0) begin failures++; $display("FAIL rst_no_write got=%0d required %0d", wr_count, wr0); end
        if (idle !== 1'b1) begin failures++; $display("FAIL rst_release_idle got=%b required 1", idle); end
    endtask

    task automatic test_random();
        int n, rd0;
        ack_rand = 1'b1;
        for (int b = 0; b < 25; b++) begin
            rd0 = rd_count;
            flush = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++)
                push(ASZ'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            model_batch();
            wait_drained("random");
            checks++;
            if (rd_count - rd0 != n) begin
                failures++;
                $display("FAIL random_reads batch=%0d got=%0d required %0d", b, rd_count - rd0, n);
            end
        end
        ack_rand = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_hold();
        test_dup_lane();
        test_stall();
        test_flush();
        test_reset_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/je_fifo_drain.md
JE_FIFO_DRAIN -- requirements
Module: je_fifo_drain

Interface
REQ-001 The block SHALL have parameter ASZ, default 17, giving the byte-address width of a FIFO entry.
REQ-002 The block SHALL have parameter HOLD, default 8, giving the idle cycles a partial word waits before issue.
REQ-003 The block SHALL have input clk, 1 bit, the clock; all logic on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit, asynchronous, active-high.
REQ-005 The block SHALL have input fifo_data, ASZ+8 bits, the FIFO head: [ASZ+7:8] byte address, [7:0] byte.
REQ-006 The block SHALL have input fifo_empty, 1 bit, the FIFO empty flag.
REQ-007 The block SHALL have output fifo_read, 1 bit, a one-cycle pop strobe.
REQ-008 The block SHALL have input flush, 1 bit, level; forces issue of a partial word when the FIFO is drained.
REQ-009 The block SHALL have output mem_req, 1 bit, the write request.
REQ-010 The block SHALL have output mem_addr, ASZ-2 bits, the word address.
REQ-011 The block SHALL have output mem_wdata, 32 bits, the write data.
REQ-012 The block SHALL have output mem_be, 4 bits, the byte enables.
REQ-013 The block SHALL have input mem_ack, 1 bit, write accept.
REQ-014 The block SHALL have output idle, 1 bit, high when state is IDLE and the word buffer is empty.

Function
REQ-015 FIFO head timing: fifo_data SHALL be treated as the valid registered head only when head_valid = !fifo_empty && !empty_q, where empty_q is fifo_empty delayed one cycle.
REQ-016 After any cycle with fifo_read=1, fifo_data SHALL NOT be sampled in the next cycle (SETTLE state).
REQ-017 Entry decode: word address = byte_addr[ASZ-1:2]; lane = byte_addr[1:0]; byte placed in mem_wdata[8*lane+7:8*lane].
REQ-018 Word buffer: holds word address, 32-bit data, 4-bit be; unused lanes SHALL read 0.
REQ-019 Mergeable: the buffer is empty, or the word addresses are equal and be[lane]=0.
REQ-020 FSM states SHALL be IDLE, CHECK, SETTLE, ISSUE.
REQ-021 IDLE: go to CHECK when head_valid.
REQ-022 CHECK with head_valid and mergeable: assert fifo_read this cycle, merge the byte, clear the hold counter; next state ISSUE if be becomes 4'b1111, else SETTLE.
REQ-023 CHECK with head_valid and not mergeable: no pop; next state ISSUE; the head is re-examined in CHECK after the ack.
REQ-024 CHECK without head_valid: if the buffer is empty, go to IDLE; else, if flush=1 or the hold counter has reached HOLD-1, go to ISSUE; else increment the hold counter and stay.
REQ-025 SETTLE: exactly one cycle, then CHECK.
REQ-026 ISSUE: mem_req=1 with mem_addr, mem_wdata and mem_be taken from the buffer, all stable until mem_ack=1 is sampled.
REQ-027 On the ack edge, the buffer SHALL be cleared and the next state SHALL be CHECK.
REQ-028 mem_ack SHALL be ignored outside ISSUE.
REQ-029 fifo_read SHALL be high only in CHECK per REQ-022; never while fifo_empty=1.
REQ-030 Write ordering SHALL match FIFO order; a duplicate lane forces issue of the older byte first.
REQ-031 Throughput: at most one pop per 2 cycles; minimum ISSUE length is 1 cycle (ack in the same cycle as req).

Reset
REQ-032 While reset=1: state IDLE; buffer, be, hold counter and empty_q cleared (empty_q=1); fifo_read=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, idle=1.
REQ-033 Reset mid-ISSUE SHALL drop mem_req immediately and discard buffered bytes; no retry after release.

Verification (ASZ=17, HOLD=8, ack in first ISSUE cycle unless stated)
REQ-034 Push addr 0x00100..0x00103 with data 11,22,33,44 -> exactly one write: mem_addr=0x0040, mem_wdata=0x44332211, mem_be=1111; 4 fifo_read pulses.
REQ-035 Push 0x00005=AA then 0x00009=BB -> write addr 0x0001 be 0010 wdata 0x0000AA00, then after 8 drained cycles write addr 0x0002 be 0010 wdata 0x0000BB00.
REQ-036 Push 0x00004=01 then 0x00004=02 -> two writes, both addr 0x0001 be 0001, wdata 0x00000001 then 0x00000002.
REQ-037 mem_ack held low 20 cycles during ISSUE -> mem_req/addr/wdata/be constant for 20 cycles and fifo_read=0; completes on the first ack.
REQ-038 Single byte 0x00003=7F with flush=1 -> mem_req within 2 cycles of the FIFO draining, be=1000, wdata=0x7F000000, no HOLD wait.
REQ-039 reset asserted during ISSUE -> mem_req=0 asynchronously; after release idle=1 and no write issued until new data arrives.
